spm_ctrl_v2: RTL and testbench

SPM_CTRL_V2 -- requirements
Module: spm_ctrl_v2

---
 rtl/spm_pkg.sv | 42 ++++
 rtl/spm_ctrl_v2.sv | 258 +++++++++++++++++++++++++
 tb/tb_spm_ctrl_v2.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_pkg.sv
// Shared constants for the SPM controller: FSM state codes, opcodes and bus-2 select codes.
// SPM_CTRL_IRQ_EN adds the interrupt states and the RTI opcode.
package spm_pkg;

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_FET1 = 4'd1,
        S_FET2 = 4'd2,
        S_DEC  = 4'd3,
        S_EX1  = 4'd4,
        S_RD1  = 4'd5,
        S_RD2  = 4'd6,
        S_WR1  = 4'd7,
        S_WR2  = 4'd8,
        S_BR1  = 4'd9,
        S_BR2  = 4'd10,
        S_HALT = 4'd11
`ifdef SPM_CTRL_IRQ_EN
        ,
        S_INT1 = 4'd12,
        S_INT2 = 4'd13
`endif
    } state_t;

    localparam int unsigned OP_NOP = 0;
    localparam int unsigned OP_ADD = 1;
    localparam int unsigned OP_SUB = 2;
    localparam int unsigned OP_AND = 3;
    localparam int unsigned OP_NOT = 4;
    localparam int unsigned OP_RD  = 5;
    localparam int unsigned OP_WR  = 6;
    localparam int unsigned OP_BR  = 7;
    localparam int unsigned OP_BRZ = 8;
    localparam int unsigned OP_EQZ = 9;
    localparam int unsigned OP_HLT = 10;
    localparam int unsigned OP_RTI = 11;

    localparam logic [1:0] BUS2_ALU  = 2'd0;
    localparam logic [1:0] BUS2_BUS1 = 2'd1;
    localparam logic [1:0] BUS2_MEM  = 2'd2;

endpackage

// File: rtl/spm_ctrl_v2.sv
// Microsequencer for the simple processor: fetch / decode / execute with memory-ready handshakes.
// Defining SPM_CTRL_IRQ_EN adds irq/irq_ack, the INT1/INT2 entry sequence and the RTI opcode.
module spm_ctrl_v2
    import spm_pkg::*;
#(
    parameter int WORD_W       = 8,
    parameter int OP_W         = 4,
    parameter int REG_AW       = 2,
    parameter int IRQ_VEC_CODE = (2 ** REG_AW) + 1,
    localparam int NUM_REGS    = 2 ** REG_AW,
    localparam int SEL1_W      = $clog2(NUM_REGS + 2)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_W-1:0]   instruction,
    input  logic                zero,
    input  logic                mem_ready,
    input  logic                go,
    output logic [NUM_REGS-1:0] load_reg,
    output logic                load_pc,
    output logic                inc_pc,
    output logic                load_ir,
    output logic                load_addr,
    output logic                load_y,
    output logic                load_z,
    output logic [SEL1_W-1:0]   sel_bus1,
    output logic [1:0]          sel_bus2,
    output logic                mem_rd,
    output logic                write,
    output logic                halted,
    output logic                illegal
`ifdef SPM_CTRL_IRQ_EN
    ,
    input  logic                irq,
    output logic                irq_ack
`endif
);

    localparam logic [SEL1_W-1:0] SEL1_PC = SEL1_W'(NUM_REGS);

    // Reject field layouts that overlap and vector codes outside the bus-1 range.
    if ((OP_W + 2 * REG_AW > WORD_W) || (IRQ_VEC_CODE > NUM_REGS + 1)) begin : g_param_check
        $error("spm_ctrl_v2: inconsistent WORD_W/OP_W/REG_AW/IRQ_VEC_CODE");
    end

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] src;
    logic [REG_AW-1:0] dest;

    assign op   = instruction[WORD_W-1 -: OP_W];
    assign src  = instruction[2*REG_AW-1:REG_AW];
    assign dest = instruction[REG_AW-1:0];

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
`ifdef SPM_CTRL_IRQ_EN
    logic   in_service_q, in_service_d;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            illegal_q    <= 1'b0;
`ifdef SPM_CTRL_IRQ_EN
            in_service_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            illegal_q    <= illegal_d;
`ifdef SPM_CTRL_IRQ_EN
            in_service_q <= in_service_d;
`endif
        end
    end

    assign illegal = illegal_q;

    always_comb begin
        // NOTE: every output and next-state value gets a default first, so no path infers a latch.
        state_d   = state_q;
        illegal_d = illegal_q;
        load_reg  = '0;
        load_pc   = 1'b0;
        inc_pc    = 1'b0;
        load_ir   = 1'b0;
        load_addr = 1'b0;
        load_y    = 1'b0;
        load_z    = 1'b0;
        sel_bus1  = '0;
        sel_bus2  = BUS2_ALU;
        mem_rd    = 1'b0;
        write     = 1'b0;
        halted    = 1'b0;
`ifdef SPM_CTRL_IRQ_EN
        in_service_d = in_service_q;
        irq_ack      = 1'b0;
`endif

        case (state_q)
            S_IDLE: state_d = S_FET1;

            S_FET1: begin
                sel_bus1  = SEL1_PC;
                sel_bus2  = BUS2_BUS1;
                load_addr = 1'b1;
                state_d   = S_FET2;
`ifdef SPM_CTRL_IRQ_EN
                if (irq && !in_service_q) state_d = S_INT1;
`endif
            end

            // Memory states hold with mem_rd/write up; strobes fire only in the ready cycle.
            S_FET2: begin
                mem_rd   = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = S_DEC;
                end
            end

            S_DEC: begin
                case (op)
                    OP_W'(OP_NOP): state_d = S_FET1;
                    OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_AND), OP_W'(OP_EQZ): begin
                        sel_bus1 = SEL1_W'(src);
                        sel_bus2 = BUS2_BUS1;
                        load_y   = 1'b1;
                        state_d  = S_EX1;
                    end
                    OP_W'(OP_NOT): begin
                        sel_bus1       = SEL1_W'(src);
                        sel_bus2       = BUS2_ALU;
                        load_z         = 1'b1;
                        load_reg[dest] = 1'b1;
                        state_d        = S_FET1;
                    end
                    OP_W'(OP_RD), OP_W'(OP_WR), OP_W'(OP_BR): begin
                        sel_bus1  = SEL1_PC;
                        sel_bus2  = BUS2_BUS1;
                        load_addr = 1'b1;
                        state_d   = (op == OP_W'(OP_RD)) ? S_RD1 :
                                    (op == OP_W'(OP_WR)) ? S_WR1 : S_BR1;
                    end
                    OP_W'(OP_BRZ): begin
                        if (zero) begin
                            sel_bus1  = SEL1_PC;
                            sel_bus2  = BUS2_BUS1;
                            load_addr = 1'b1;
                            state_d   = S_BR1;
                        end else begin
                            inc_pc  = 1'b1;
                            state_d = S_FET1;
                        end
                    end
                    OP_W'(OP_HLT): state_d = S_HALT;
`ifdef SPM_CTRL_IRQ_EN
                    OP_W'(OP_RTI): begin
                        sel_bus1     = SEL1_W'(NUM_REGS - 1);
                        sel_bus2     = BUS2_BUS1;
                        load_pc      = 1'b1;
                        in_service_d = 1'b0;
                        state_d      = S_FET1;
                    end
`endif
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end

            S_EX1: begin
                sel_bus1       = SEL1_W'(dest);
                sel_bus2       = BUS2_ALU;
                load_z         = 1'b1;
                load_reg[dest] = 1'b1;
                state_d        = S_FET1;
            end

            // RD1/WR1/BR1 read the operand address word that follows the opcode.
            S_RD1, S_WR1: begin
                mem_rd   = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_addr = 1'b1;
                    inc_pc    = 1'b1;
                    state_d   = (state_q == S_RD1) ? S_RD2 : S_WR2;
                end
            end

            S_RD2: begin
                mem_rd   = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_reg[dest] = 1'b1;
                    state_d        = S_FET1;
                end
            end

            S_WR2: begin
                write    = 1'b1;
                sel_bus1 = SEL1_W'(src);
                if (mem_ready) state_d = S_FET1;
            end

            S_BR1: begin
                mem_rd   = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_addr = 1'b1;
                    state_d   = S_BR2;
                end
            end

            S_BR2: begin
                mem_rd   = 1'b1;
                sel_bus2 = BUS2_MEM;
                if (mem_ready) begin
                    load_pc = 1'b1;
                    state_d = S_FET1;
                end
            end

            S_HALT: begin
                halted = 1'b1;
                if (go) begin
                    illegal_d = 1'b0;
                    state_d   = S_FET1;
                end
            end

`ifdef SPM_CTRL_IRQ_EN
            // Return address is parked in the top register before jumping to the vector.
            S_INT1: begin
                sel_bus1                = SEL1_PC;
                sel_bus2                = BUS2_BUS1;
                load_reg[NUM_REGS-1]    = 1'b1;
                irq_ack                 = 1'b1;
                in_service_d            = 1'b1;
                state_d                 = S_INT2;
            end

            S_INT2: begin
                sel_bus1 = SEL1_W'(IRQ_VEC_CODE);
                sel_bus2 = BUS2_BUS1;
                load_pc  = 1'b1;
                state_d  = S_FET1;
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_spm_ctrl_v2.sv
// Randomized self-checking bench for spm_ctrl_v2: per-opcode cycle scripts with random memory waits.
// Exercises the interrupt path when SPM_CTRL_IRQ_EN is defined.
module tb_spm_ctrl_v2;

    typedef struct packed {
        logic [3:0] load_reg;
        logic       load_pc;
        logic       inc_pc;
        logic       load_ir;
        logic       load_addr;
        logic       load_y;
        logic       load_z;
        logic [2:0] sel_bus1;
        logic [1:0] sel_bus2;
        logic       mem_rd;
        logic       write;
        logic       halted;
        logic       illegal;
        logic       irq_ack;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instruction = 8'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       go = 1'b0;
    logic       irq = 1'b0;

    logic [3:0] load_reg;
    logic       load_pc, inc_pc, load_ir, load_addr, load_y, load_z;
    logic [2:0] sel_bus1;
    logic [1:0] sel_bus2;
    logic       mem_rd, write, halted, illegal;
    logic       irq_ack;

    int   checks = 0;
    int   errors = 0;
    logic [7:0] cur_ins = 8'h00;
    bit   in_service_m = 1'b0;

    spm_ctrl_v2 dut (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .go          (go),
        .load_reg    (load_reg),
        .load_pc     (load_pc),
        .inc_pc      (inc_pc),
        .load_ir     (load_ir),
        .load_addr   (load_addr),
        .load_y      (load_y),
        .load_z      (load_z),
        .sel_bus1    (sel_bus1),
        .sel_bus2    (sel_bus2),
        .mem_rd      (mem_rd),
        .write       (write),
        .halted      (halted),
        .illegal     (illegal)
`ifdef SPM_CTRL_IRQ_EN
        ,
        .irq         (irq),
        .irq_ack     (irq_ack)
`endif
    );

`ifndef SPM_CTRL_IRQ_EN
    assign irq_ack = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input out_t obs, input out_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.load_reg  = load_reg;
        o.load_pc   = load_pc;
        o.inc_pc    = inc_pc;
        o.load_ir   = load_ir;
        o.load_addr = load_addr;
        o.load_y    = load_y;
        o.load_z    = load_z;
        o.sel_bus1  = sel_bus1;
        o.sel_bus2  = sel_bus2;
        o.mem_rd    = mem_rd;
        o.write     = write;
        o.halted    = halted;
        o.illegal   = illegal;
        o.irq_ack   = irq_ack;
        return o;
    endfunction

    function automatic out_t blank();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t no_sel(input out_t o);
        out_t r = o;
        r.sel_bus1 = '0;
        r.sel_bus2 = '0;
        return r;
    endfunction

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic out_t fet1_exp();
        out_t e = blank();
        e.sel_bus1  = 3'd4;
        e.sel_bus2  = 2'd1;
        e.load_addr = 1'b1;
        return e;
    endfunction

    function automatic out_t fetch_addr_exp();
        return fet1_exp();
    endfunction

    // Inputs change just after the falling edge; outputs are checked 1 time unit later.
    task automatic drive_cycle(input bit zero_v, input bit irq_v, input bit go_v, input bit ready_v);
        @(negedge clk);
        instruction = cur_ins;
        zero        = zero_v;
        irq         = irq_v;
        go          = go_v;
        mem_ready   = ready_v;
        #1;
    endtask

    task automatic plain_cycle(input string tag, input out_t e, input bit zero_v, input bit irq_v,
                               input bit go_v);
        drive_cycle(zero_v, irq_v, go_v, rb());
        check(tag, sample(), e);
    endtask

    task automatic mem_wait(input string tag, input out_t e, input int waits);
        out_t w = blank();
        w.mem_rd = e.mem_rd;
        w.write  = e.write;
        for (int i = 0; i < waits; i++) begin
            drive_cycle(rb(), rb(), rb(), 1'b0);
            check({tag, "_wait"}, no_sel(sample()), w);
        end
    endtask

    task automatic mem_cycle(input string tag, input out_t e, input int waits);
        mem_wait(tag, e, waits);
        drive_cycle(rb(), rb(), rb(), 1'b1);
        check(tag, sample(), e);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = rb();
        go        = rb();
        #1;
        check(tag, sample(), blank());
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, "_idle"}, sample(), blank());
        in_service_m = 1'b0;
    endtask

    task automatic halt_seq(input bit ill);
        out_t e = blank();
        int   k = $urandom_range(0, 3);
        e.halted  = 1'b1;
        e.illegal = ill;
        for (int i = 0; i < k; i++) plain_cycle("halt", e, rb(), rb(), 1'b0);
        plain_cycle("halt_go", e, rb(), rb(), 1'b1);
    endtask

    // One instruction from FET1 until the cycle before the next FET1.
    task automatic run_instr(input logic [7:0] ins, input int fixed_wait, input int zero_force,
                             input int irq_force, input bit rst_wr2);
        int   op, src, dst;
        bit   zv, iv, rti_ok;
        out_t e;
        op  = int'(ins[7:4]);
        src = int'(ins[3:2]);
        dst = int'(ins[1:0]);
`ifdef SPM_CTRL_IRQ_EN
        rti_ok = 1'b1;
`else
        rti_ok = 1'b0;
`endif
        iv      = (irq_force >= 0) ? irq_force[0] : ($urandom_range(0, 3) == 0);
        cur_ins = ins;

        plain_cycle("fet1", fet1_exp(), rb(), iv, rb());
`ifdef SPM_CTRL_IRQ_EN
        if (iv && !in_service_m) begin
            e = blank();
            e.sel_bus1 = 3'd4;
            e.sel_bus2 = 2'd1;
            e.load_reg = 4'b1000;
            e.irq_ack  = 1'b1;
            plain_cycle("int1", e, rb(), rb(), rb());
            in_service_m = 1'b1;
            e = blank();
            e.sel_bus1 = 3'd5;
            e.sel_bus2 = 2'd1;
            e.load_pc  = 1'b1;
            plain_cycle("int2", e, rb(), rb(), rb());
            plain_cycle("fet1_after_int", fet1_exp(), rb(), rb(), rb());
        end
`endif

        e = blank();
        e.sel_bus2 = 2'd2;
        e.load_ir  = 1'b1;
        e.inc_pc   = 1'b1;
        e.mem_rd   = 1'b1;
        mem_cycle("fet2", e, (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3));

        zv = (zero_force >= 0) ? zero_force[0] : rb();
        e  = blank();
        case (op)
            0: plain_cycle("dec_nop", e, zv, rb(), rb());
            1, 2, 3, 9: begin
                e.sel_bus1 = 3'(src);
                e.sel_bus2 = 2'd1;
                e.load_y   = 1'b1;
                plain_cycle("dec_alu", e, zv, rb(), rb());
                e = blank();
                e.sel_bus1      = 3'(dst);
                e.load_z        = 1'b1;
                e.load_reg[dst] = 1'b1;
                plain_cycle("ex1", e, rb(), rb(), rb());
            end
            4: begin
                e.sel_bus1      = 3'(src);
                e.load_z        = 1'b1;
                e.load_reg[dst] = 1'b1;
                plain_cycle("dec_not", e, zv, rb(), rb());
            end
            5, 6, 7, 8: begin
                if (op == 8 && !zv) begin
                    e.inc_pc = 1'b1;
                    plain_cycle("dec_brz_nt", e, zv, rb(), rb());
                end else begin
                    plain_cycle("dec_mem", fetch_addr_exp(), zv, rb(), rb());
                    e = blank();
                    e.mem_rd   = 1'b1;
                    e.sel_bus2 = 2'd2;
                    e.load_addr = 1'b1;
                    if (op == 5 || op == 6) e.inc_pc = 1'b1;
                    mem_cycle("mem1", e, (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3));
                    e = blank();
                    if (op == 5) begin
                        e.mem_rd        = 1'b1;
                        e.sel_bus2      = 2'd2;
                        e.load_reg[dst] = 1'b1;
                        mem_cycle("rd2", e, (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3));
                    end else if (op == 6) begin
                        e.write    = 1'b1;
                        e.sel_bus1 = 3'(src);
                        if (rst_wr2) begin
                            mem_wait("wr2", e, $urandom_range(1, 2));
                            apply_reset("rst_wr2");
                        end else begin
                            mem_cycle("wr2", e, (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3));
                        end
                    end else begin
                        e.mem_rd   = 1'b1;
                        e.sel_bus2 = 2'd2;
                        e.load_pc  = 1'b1;
                        mem_cycle("br2", e, (fixed_wait >= 0) ? fixed_wait : $urandom_range(0, 3));
                    end
                end
            end
            10: begin
                plain_cycle("dec_hlt", e, zv, rb(), rb());
                halt_seq(1'b0);
            end
            default: begin
                if (op == 11 && rti_ok) begin
                    e.sel_bus1 = 3'd3;
                    e.sel_bus2 = 2'd1;
                    e.load_pc  = 1'b1;
                    plain_cycle("dec_rti", e, zv, rb(), rb());
                    in_service_m = 1'b0;
                end else begin
                    plain_cycle("dec_illegal", e, zv, rb(), rb());
                    halt_seq(1'b1);
                end
            end
        endcase
    endtask

    initial begin
        apply_reset("reset");

        run_instr(8'h16, 0, -1, 0, 1'b0);
        run_instr(8'h53, 3, -1, 0, 1'b0);
        run_instr(8'h80, -1, 0, 0, 1'b0);
        run_instr(8'h80, -1, 1, 0, 1'b0);
        run_instr(8'hF0, -1, -1, 0, 1'b0);
        run_instr(8'hA0, -1, -1, 0, 1'b0);
        run_instr(8'hB0, -1, -1, 0, 1'b0);
        run_instr(8'h6D, 1, -1, 0, 1'b1);
        run_instr(8'h4B, -1, -1, 0, 1'b0);
`ifdef SPM_CTRL_IRQ_EN
        run_instr(8'h16, 0, -1, 1, 1'b0);
        run_instr(8'h27, 0, -1, 1, 1'b0);
        run_instr(8'hB0, 0, -1, 1, 1'b0);
        run_instr(8'h00, 0, -1, 1, 1'b0);
        run_instr(8'hB0, 0, -1, 0, 1'b0);
`endif

        for (int n = 0; n < 400; n++) begin
            logic [7:0] ins;
            ins = 8'($urandom_range(0, 255));
            run_instr(ins, -1, -1, -1, (ins[7:4] == 4'd6) && ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
